// File: rtl/factorial_driver.sv
// factorial_driver: runs operands first_op..last_op through an external factorial engine.
// Define FACT_CHECK_EN to add an on-chip reference factorial and the sticky mismatch flag.
module factorial_driver #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  first_op,
    input  logic [3:0]  last_op,
    output logic        load,
    output logic [3:0]  operand,
    input  logic        done,
    input  logic [40:0] product,
    output logic        dack,
    output logic        res_valid,
    output logic [3:0]  res_operand,
    output logic [40:0] res_product,
    output logic        busy,
    output logic        seq_done,
    output logic        timeout,
    output logic        mismatch
);
    localparam int unsigned CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {IDLE, PREP, LOAD, WAIT_DONE, ACK, WAIT_CLR} state_t;

    state_t        state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [3:0]    last_q, last_d;
    logic [3:0]    res_op_q, res_op_d;
    logic [40:0]   res_prod_q, res_prod_d;
    logic          busy_q, busy_d;
    logic          seq_done_q, seq_done_d;
    logic          timeout_q, timeout_d;
    logic [CW-1:0] cnt_q, cnt_d;
`ifdef FACT_CHECK_EN
    logic [40:0]   exp_q, exp_d;
    logic [4:0]    k_q, k_d;
    logic          mismatch_q, mismatch_d;
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        last_d     = last_q;
        res_op_d   = res_op_q;
        res_prod_d = res_prod_q;
        busy_d     = busy_q;
        seq_done_d = 1'b0;
        timeout_d  = timeout_q;
        cnt_d      = cnt_q;
`ifdef FACT_CHECK_EN
        exp_d      = exp_q;
        k_d        = k_q;
        mismatch_d = mismatch_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    timeout_d = 1'b0;
                    if (first_op > last_op) begin
                        seq_done_d = 1'b1;
                    end else begin
                        op_d   = first_op;
                        last_d = last_op;
                        busy_d = 1'b1;
`ifdef FACT_CHECK_EN
                        exp_d   = 41'd1;
                        k_d     = 5'd2;
                        state_d = PREP;
`else
                        state_d = LOAD;
`endif
                    end
                end
            end
`ifdef FACT_CHECK_EN
            // One factor per cycle; k passing first_op (or first_op<=1) ends the loop.
            PREP: begin
                if (k_q <= {1'b0, op_q}) exp_d = exp_q * 41'(k_q);
                if (k_q >= {1'b0, op_q}) state_d = LOAD;
                k_d = k_q + 5'd1;
            end
`endif
            LOAD: begin
                // Timer measures cycles since the load pulse, so it starts at 1.
                cnt_d   = CW'(1);
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done) begin
                    res_op_d   = op_q;
                    res_prod_d = product;
`ifdef FACT_CHECK_EN
                    if (product != exp_q) mismatch_d = 1'b1;
`endif
                    state_d = ACK;
                end else if (cnt_q >= CW'(TIMEOUT_CYC - 1)) begin
                    timeout_d  = 1'b1;
                    seq_done_d = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ACK: state_d = WAIT_CLR;
            WAIT_CLR: begin
                if (!done) begin
                    if (op_q == last_q) begin
                        seq_done_d = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        op_d = op_q + 4'd1;
`ifdef FACT_CHECK_EN
                        exp_d = exp_q * 41'(op_q + 4'd1);
`endif
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            last_q     <= '0;
            res_op_q   <= '0;
            res_prod_q <= '0;
            busy_q     <= 1'b0;
            seq_done_q <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
`ifdef FACT_CHECK_EN
            exp_q      <= '0;
            k_q        <= '0;
            mismatch_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            last_q     <= last_d;
            res_op_q   <= res_op_d;
            res_prod_q <= res_prod_d;
            busy_q     <= busy_d;
            seq_done_q <= seq_done_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
`ifdef FACT_CHECK_EN
            exp_q      <= exp_d;
            k_q        <= k_d;
            mismatch_q <= mismatch_d;
`endif
        end
    end

    assign load        = (state_q == LOAD);
    assign dack        = (state_q == ACK);
    assign res_valid   = (state_q == ACK);
    assign operand     = op_q;
    assign res_operand = res_op_q;
    assign res_product = res_prod_q;
    assign busy        = busy_q;
    assign seq_done    = seq_done_q;
    assign timeout     = timeout_q;
`ifdef FACT_CHECK_EN
    assign mismatch    = mismatch_q;
`else
    assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_factorial_driver.sv
// Bench for factorial_driver: behavioural engine, scoreboard of expected loads/results, directed tests.
module tb_factorial_driver;
    localparam int unsigned TO = 16;
`ifdef FACT_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  first_op = '0;
    logic [3:0]  last_op = '0;
    logic        load, dack, res_valid, busy, seq_done, timeout, mismatch;
    logic [3:0]  operand, res_operand;
    logic [40:0] res_product;
    logic        done;
    logic [40:0] product;

    factorial_driver #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .first_op(first_op), .last_op(last_op),
        .load(load), .operand(operand), .done(done), .product(product), .dack(dack),
        .res_valid(res_valid), .res_operand(res_operand), .res_product(res_product),
        .busy(busy), .seq_done(seq_done), .timeout(timeout), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [40:0] prod;
    } res_t;

    logic [3:0]  exp_ld[$];
    res_t        exp_res[$];
    logic [40:0] obs[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          seq_cnt = 0;
    logic        mis_exp = 1'b0;
    int          eng_mode = 0;  // 0 correct, 1 never done, 2 returns 25 for operand 4
    int          eng_lat = 2;
    int          eng_hold = 1;
    logic        stray_req = 1'b0;

    function automatic logic [40:0] fact(input int n);
        longint f;
        f = 1;
        for (int i = 2; i <= n; i++) f = f * i;
        return 41'(f);
    endfunction

    function automatic logic [40:0] resp(input int n);
        if (eng_mode == 2 && n == 4) return 41'd25;
        return fact(n);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Engine model: answers load after eng_lat cycles, drops done eng_hold cycles after dack.
    initial begin : engine
        int         pend;
        int         drop;
        logic [3:0] pend_op;
        logic       stray_on;
        pend = -1; drop = -1; pend_op = '0; stray_on = 1'b0;
        done = 1'b0; product = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done = 1'b0; pend = -1; drop = -1;
            end else begin
                if (dack) drop = eng_hold;
                else if (drop > 0) drop--;
                if (drop == 0) begin done = 1'b0; drop = -1; end
                if (load && eng_mode != 1) begin pend = eng_lat; pend_op = operand; end
                else if (pend > 0) pend--;
                if (pend == 0) begin done = 1'b1; product = resp(int'(pend_op)); pend = -1; end
                if (stray_req && !stray_on) begin done = 1'b1; product = 41'd99; stray_on = 1'b1; end
                else if (!stray_req && stray_on) begin done = 1'b0; stray_on = 1'b0; end
            end
        end
    end

    // Per-cycle scoreboard compare.
    always @(negedge clk) begin : cmp
        res_t e;
        if (rst) begin
            exp_ld.delete();
            exp_res.delete();
            mis_exp = 1'b0;
        end else begin
            check("dack_eq_res_valid", 64'(dack), 64'(res_valid));
            if (load) begin
                check("busy_during_load", 64'(busy), 64'd1);
                if (exp_ld.size() > 0) check("load_operand", 64'(operand), 64'(exp_ld.pop_front()));
                else check("load_spurious", 64'(load), 64'd0);
            end
            if (res_valid) begin
                check("operand_held", 64'(operand), 64'(res_operand));
                if (exp_res.size() > 0) begin
                    e = exp_res.pop_front();
                    check("res_operand", 64'(res_operand), 64'(e.op));
                    check("res_product", 64'(res_product), 64'(e.prod));
                    obs.push_back(res_product);
                    if (CHECK_EN && res_product != fact(int'(res_operand))) mis_exp = 1'b1;
                end else begin
                    check("res_spurious", 64'(res_valid), 64'd0);
                end
            end
            if (seq_done) begin
                seq_cnt++;
                check("busy_at_seq_done", 64'(busy), 64'd0);
            end
            check("mismatch_flag", 64'(mismatch), 64'(mis_exp));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_range(input int a, input int b);
        res_t r;
        for (int k = a; k <= b; k++) begin
            exp_ld.push_back(4'(k));
            r.op = 4'(k);
            r.prod = resp(k);
            exp_res.push_back(r);
        end
    endtask

    task automatic run_seq(input int a, input int b, input int lat, input int hold);
        int s0;
        eng_lat = lat;
        eng_hold = hold;
        push_range(a, b);
        s0 = seq_cnt;
        first_op = 4'(a);
        last_op = 4'(b);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 600 && seq_cnt == s0; i++) step();
        check("seq_done_count", 64'(seq_cnt), 64'(s0 + 1));
        check("loads_consumed", 64'(exp_ld.size()), 64'd0);
        check("results_consumed", 64'(exp_res.size()), 64'd0);
        repeat (3) step();
        check("seq_done_single", 64'(seq_cnt), 64'(s0 + 1));
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({load, dack, res_valid, busy, seq_done, timeout, mismatch,
                    operand, res_operand, res_product});
    endfunction

    initial begin : stim
        int          s0;
        int          o0;
        logic [40:0] lit [5];
        lit = '{41'd1, 41'd1, 41'd2, 41'd6, 41'd24};

        repeat (2) step();
        check("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;
        step();

        // 0..4 with a correct engine
        o0 = obs.size();
        run_seq(0, 4, 2, 1);
        check("r0_4_count", 64'(obs.size() - o0), 64'd5);
        for (int i = 0; i < 5; i++)
            if (o0 + i < obs.size()) check("r0_4_product", 64'(obs[o0 + i]), 64'(lit[i]));
        check("r0_4_timeout", 64'(timeout), 64'd0);
        check("r0_4_mismatch", 64'(mismatch), 64'd0);

        // 15..15: largest result, must not overflow, no operand wrap
        o0 = obs.size();
        run_seq(15, 15, 3, 0);
        check("r15_count", 64'(obs.size() - o0), 64'd1);
        if (obs.size() > o0) check("r15_product", 64'(obs[o0]), 64'd1307674368000);

        // empty range 5..3
        s0 = seq_cnt;
        first_op = 4'd5; last_op = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        check("inv_seq_done", 64'(seq_done), 64'd1);
        check("inv_busy", 64'(busy), 64'd0);
        step();
        check("inv_seq_done_pulse", 64'(seq_done), 64'd0);
        check("inv_busy_after", 64'(busy), 64'd0);
        repeat (4) step();
        check("inv_seq_cnt", 64'(seq_cnt), 64'(s0 + 1));

        // engine never answers: timeout 16 cycles after load
        eng_mode = 1;
        exp_ld.push_back(4'd3);
        first_op = 4'd3; last_op = 4'd6; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 40 && !load; i++) step();
        check("to_load_seen", 64'(load), 64'd1);
        repeat (15) step();
        check("to_not_early", 64'(seq_done), 64'd0);
        step();
        check("to_seq_done", 64'(seq_done), 64'd1);
        check("to_flag", 64'(timeout), 64'd1);
        check("to_busy", 64'(busy), 64'd0);
        repeat (3) step();
        check("to_sticky", 64'(timeout), 64'd1);
        check("to_loads_consumed", 64'(exp_ld.size()), 64'd0);
        eng_mode = 0;

        // reset while waiting on operand 2, then clean restart
        s0 = seq_cnt;
        eng_lat = 6; eng_hold = 1;
        push_range(1, 5);
        first_op = 4'd1; last_op = 4'd5; start = 1'b1;
        step();
        start = 1'b0;
        check("start_clears_timeout", 64'(timeout), 64'd0);
        for (int i = 0; i < 200 && !(load && operand == 4'd2); i++) step();
        check("rst_reached_op2", 64'({load, operand}), 64'({1'b1, 4'd2}));
        step();
        step();
        check("rst_pre_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_outputs_now", all_outs(), 64'd0);
        step();
        step();
        rst = 1'b0;
        repeat (10) step();
        check("rst_no_seq_done", 64'(seq_cnt), 64'(s0));
        check("rst_idle_busy", 64'(busy), 64'd0);
        run_seq(1, 3, 1, 0);

        // engine returns 25 for operand 4
        eng_mode = 2;
        o0 = obs.size();
        run_seq(3, 6, 2, 2);
        if (obs.size() > o0 + 1) check("bad_engine_product", 64'(obs[o0 + 1]), 64'd25);
        check("bad_engine_mismatch", 64'(mismatch), 64'(CHECK_EN));
        eng_mode = 0;

        // done high while idle is ignored
        s0 = seq_cnt;
        stray_req = 1'b1;
        repeat (5) step();
        check("stray_busy", 64'(busy), 64'd0);
        check("stray_seq_cnt", 64'(seq_cnt), 64'(s0));
        stray_req = 1'b0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1);
    end

endmodule

// File: doc/factorial_driver.md
FACTORIAL_DRIVER -- requirements
Module: factorial_driver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning the maximum number of cycles to wait for done after load.
REQ-002 SHALL have port clk  in  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-004 SHALL have port start  in  1  one-cycle request to run an operand sequence.
REQ-005 SHALL have port first_op  in  4 (int_types::INT04_t)  first operand of the sequence.
REQ-006 SHALL have port last_op  in  4 (int_types::INT04_t)  last operand of the sequence, inclusive.
REQ-007 SHALL have port load  out  1  request pulse to the factorial engine.
REQ-008 SHALL have port operand  out  4 (int_types::INT04_t)  operand presented to the engine.
REQ-009 SHALL have port done  in  1  engine result-ready flag, held high until acknowledged.
REQ-010 SHALL have port product  in  41 (int_types::INT41_t)  engine result, valid while done=1.
REQ-011 SHALL have port dack  out  1  one-cycle acknowledge of a captured result.
REQ-012 SHALL have port res_valid  out  1  one-cycle strobe marking a captured result.
REQ-013 SHALL have port res_operand  out  4  operand belonging to the captured result.
REQ-014 SHALL have port res_product  out  41  captured product.
REQ-015 SHALL have port busy  out  1  high from accepted start until the sequence ends.
REQ-016 SHALL have port seq_done  out  1  one-cycle strobe at the end of a sequence.
REQ-017 SHALL have port timeout  out  1  sticky error flag, cleared only by reset or an accepted start.
REQ-018 SHALL have port mismatch  out  1  sticky check-error flag; tied to 0 when FACT_CHECK_EN is undefined.

Function
REQ-019 SHALL implement the FSM states IDLE, PREP, LOAD, WAIT_DONE, ACK, WAIT_CLR.
REQ-020 SHALL accept start only in IDLE; start in any other state SHALL be ignored.
REQ-021 On an accepted start with first_op > last_op, SHALL pulse seq_done on the next cycle and SHALL remain in IDLE with no load issued.
REQ-022 On an accepted start with a valid range, SHALL latch first_op and last_op, set busy, and go to PREP (FACT_CHECK_EN defined) or LOAD (undefined).
REQ-023 In LOAD, SHALL drive load=1 for exactly one cycle with operand equal to the current operand, then go to WAIT_DONE.
REQ-024 operand SHALL hold its value from LOAD until the corresponding dack.
REQ-025 In WAIT_DONE, on the cycle done=1 is sampled, SHALL register product into res_product and operand into res_operand, and go to ACK.
REQ-026 In ACK, SHALL assert dack=1 and res_valid=1 for exactly one cycle, then go to WAIT_CLR.
REQ-027 In WAIT_CLR, SHALL wait for done=0; if the operand equals last_op, SHALL then pulse seq_done, clear busy and return to IDLE; otherwise SHALL increment the operand and go to LOAD.
REQ-028 Operand increment SHALL NOT wrap; last_op=15 SHALL terminate after operand 15.
REQ-029 SHALL count cycles spent in WAIT_DONE; on reaching TIMEOUT_CYC with done=0, SHALL set timeout, pulse seq_done, clear busy and return to IDLE without issuing dack.
REQ-030 A done that is high in LOAD or IDLE SHALL be ignored.

Reset
REQ-031 While rst=1, SHALL force state to IDLE and set load, dack, res_valid, busy, seq_done, timeout and mismatch to 0, operand to 0, res_operand to 0 and res_product to 0.
REQ-032 Reset asserted mid-sequence SHALL abort the sequence immediately, with no dack or seq_done issued afterwards.

Configuration
REQ-033 With macro FACT_CHECK_EN defined, SHALL compute first_op! in PREP by iterated 41-bit multiplication (one cycle per factor k=2..first_op; first_op<=1 takes one cycle).
REQ-034 With FACT_CHECK_EN defined, SHALL then update the expected value as expected*operand per step and set mismatch when a captured product differs from it.
REQ-035 With FACT_CHECK_EN undefined, SHALL omit PREP and the multiplier entirely and SHALL hold mismatch at 0.

Verification
REQ-036 SHALL cover first_op=0, last_op=4 with a correct engine -> res_product 1,1,2,6,24 in order; one seq_done; mismatch=0.
REQ-037 SHALL cover first_op=last_op=15 -> single result 1307674368000 with no overflow; mismatch=0 with FACT_CHECK_EN defined.
REQ-038 SHALL cover first_op=5, last_op=3 -> no load; seq_done one cycle after start; busy stays 0.
REQ-039 SHALL cover an engine that never raises done, with TIMEOUT_CYC=16 -> timeout=1 and seq_done 16 cycles after load; no dack.
REQ-040 SHALL cover rst asserted in WAIT_DONE of operand 2 -> all outputs 0 in the same cycle; a new start restarts cleanly from first_op.
REQ-041 SHALL cover an engine returning 25 for operand 4, with FACT_CHECK_EN defined -> mismatch=1 after that capture and the sequence still completes.
